// File: rtl/fizzbuzz_pkg.sv
// Shared definitions for the FizzBuzz line generator: character codes, run states
// and an elaboration-time integer-to-BCD helper.
package fizzbuzz_pkg;

    localparam logic [3:0] CHAR_B     = 4'd10;
    localparam logic [3:0] CHAR_F     = 4'd11;
    localparam logic [3:0] CHAR_I     = 4'd12;
    localparam logic [3:0] CHAR_U     = 4'd13;
    localparam logic [3:0] CHAR_Z     = 4'd14;
    localparam logic [3:0] CHAR_BLANK = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2,
        DONE = 2'd3
    } state_e;

    // Converts a parameter value to packed BCD (up to 8 digits), used to build the LIMIT compare.
    function automatic logic [31:0] int_to_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned rem;
        r   = '0;
        rem = v;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(rem % 10);
            rem         = rem / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/fizzbuzz_gen_bcd_counter.sv
// N-digit BCD counter with synchronous load-to-1 and increment; each digit wraps 9 -> 0
// and carries into the next.
module bcd_counter_n #(
    parameter int NDIGITS = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic                   inc_i,
    output logic [4*NDIGITS-1:0]   count_o
);

    logic [4*NDIGITS-1:0] count_q;
    logic [4*NDIGITS-1:0] count_d;
    logic [4*NDIGITS-1:0] count_inc;
    logic                 carry;

    always_comb begin
        count_inc = count_q;
        carry     = 1'b1;
        for (int k = 0; k < NDIGITS; k++) begin
            if (carry) begin
                if (count_q[4*k +: 4] == 4'd9) begin
                    count_inc[4*k +: 4] = 4'd0;
                end else begin
                    count_inc[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = {{(4*NDIGITS-1){1'b0}}, 1'b1};
        end else if (inc_i) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fizzbuzz_gen.sv
// FizzBuzz line generator with valid/ready output and start/done control.
// Define FIZZBUZZ_GEN_WRAP_EN to restart from 1 after LIMIT instead of stopping in DONE.
module fizzbuzz_gen
    import fizzbuzz_pkg::*;
#(
    parameter int NDIGITS = 3,
    parameter int LIMIT   = 100,
    parameter int DIV_A   = 3,
    parameter int DIV_B   = 5,
    parameter int NCHARS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [4*NCHARS-1:0]   line,
    output logic                  isnum,
    output logic [4*NDIGITS-1:0]  value,
    output logic                  done
);

    localparam int MA_W = $clog2(DIV_A);
    localparam int MB_W = $clog2(DIV_B);
    localparam logic [31:0]          LIMIT_BCD32 = int_to_bcd(LIMIT);
    localparam logic [4*NDIGITS-1:0] LIMIT_BCD   = LIMIT_BCD32[4*NDIGITS-1:0];

    state_e state_q, state_d;

    logic                 cnt_load;
    logic                 cnt_inc;
    logic                 line_load;
    logic [4*NDIGITS-1:0] count;
    logic [MA_W-1:0]      mod_a_q;
    logic [MB_W-1:0]      mod_b_q;
    logic [4*NCHARS-1:0]  line_q, fmt_line;
    logic                 isnum_q, fmt_isnum;
    logic [4*NDIGITS-1:0] value_q;
    int                   nsig;

    bcd_counter_n #(.NDIGITS(NDIGITS)) u_counter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (cnt_load),
        .inc_i   (cnt_inc),
        .count_o (count)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        line_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_load = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                line_load = 1'b1;
                state_d   = SHOW;
            end
            SHOW: begin
                if (out_ready) begin
                    if (count == LIMIT_BCD) begin
`ifdef FIZZBUZZ_GEN_WRAP_EN
                        cnt_load = 1'b1;
                        state_d  = LOAD;
`else
                        state_d  = DONE;
`endif
                    end else begin
                        cnt_inc = 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    cnt_load = 1'b1;
                    state_d  = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Residues track count mod DIV alongside the counter, avoiding any divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            mod_a_q <= '0;
            mod_b_q <= '0;
        end else if (cnt_load) begin
            mod_a_q <= MA_W'(1 % DIV_A);
            mod_b_q <= MB_W'(1 % DIV_B);
        end else if (cnt_inc) begin
            mod_a_q <= (mod_a_q == MA_W'(DIV_A - 1)) ? '0 : mod_a_q + 1'b1;
            mod_b_q <= (mod_b_q == MB_W'(DIV_B - 1)) ? '0 : mod_b_q + 1'b1;
        end
    end

    always_comb begin
        fmt_line  = '1;
        fmt_isnum = 1'b0;
        nsig      = 1;
        if (mod_a_q == '0 && mod_b_q == '0) begin
            fmt_line[31:0] = {CHAR_Z, CHAR_Z, CHAR_U, CHAR_B, CHAR_Z, CHAR_Z, CHAR_I, CHAR_F};
        end else if (mod_a_q == '0) begin
            fmt_line[15:0] = {CHAR_Z, CHAR_Z, CHAR_I, CHAR_F};
        end else if (mod_b_q == '0) begin
            fmt_line[15:0] = {CHAR_Z, CHAR_Z, CHAR_U, CHAR_B};
        end else begin
            fmt_isnum = 1'b1;
            for (int k = 0; k < NDIGITS; k++) begin
                if (count[4*k +: 4] != 4'd0) nsig = k + 1;
            end
            // Most significant non-zero digit lands in char 0.
            for (int i = 0; i < NDIGITS; i++) begin
                if (i < nsig) fmt_line[4*i +: 4] = count[4*(nsig-1-i) +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q  <= '1;
            isnum_q <= 1'b0;
            value_q <= '0;
        end else if (line_load) begin
            line_q  <= fmt_line;
            isnum_q <= fmt_isnum;
            value_q <= count;
        end
    end

    assign out_valid = (state_q == SHOW);
    assign done      = (state_q == DONE);
    assign line      = line_q;
    assign isnum     = isnum_q;
    assign value     = value_q;

endmodule

// File: tb/tb_fizzbuzz_gen.sv
// Directed self-checking bench for fizzbuzz_gen: default instance plus a LIMIT=200 instance.
module tb_fizzbuzz_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, ready_a = 1'b0;
    logic        start_b = 1'b0, ready_b = 1'b0;
    logic        valid_a, isnum_a, done_a;
    logic        valid_b, isnum_b, done_b;
    logic [31:0] line_a, line_b;
    logic [11:0] value_a, value_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fizzbuzz_gen dut_a (
        .clk(clk), .rst(rst), .start(start_a), .out_ready(ready_a),
        .out_valid(valid_a), .line(line_a), .isnum(isnum_a), .value(value_a), .done(done_a)
    );

    fizzbuzz_gen #(.LIMIT(200)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .out_ready(ready_b),
        .out_valid(valid_b), .line(line_b), .isnum(isnum_b), .value(value_b), .done(done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a valid line on the selected instance, captures it, then completes one transfer.
    task automatic get_line(input bit sel, output logic [31:0] l, output logic n,
                            output logic [11:0] v);
        bit ok;
        ok = 1'b0;
        l  = '0; n = 1'b0; v = '0;
        for (int c = 0; c < 8; c++) begin
            if ((sel ? valid_b : valid_a) === 1'b1) begin
                l = sel ? line_b  : line_a;
                n = sel ? isnum_b : isnum_a;
                v = sel ? value_b : value_a;
                if (sel) ready_b = 1'b1; else ready_a = 1'b1;
                tick();
                ready_a = 1'b0;
                ready_b = 1'b0;
                ok      = 1'b1;
                break;
            end
            tick();
        end
        check("handshake_seen", {31'd0, ok}, 32'd1);
    endtask

    logic [31:0] l;
    logic        n;
    logic [11:0] v;

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", {31'd0, valid_a}, 32'd0);
        check("rst_done",  {31'd0, done_a},  32'd0);
        check("rst_isnum", {31'd0, isnum_a}, 32'd0);
        check("rst_line",  line_a, 32'hFFFFFFFF);
        check("rst_value", {20'd0, value_a}, 32'd0);

        // start -> LOAD next cycle, SHOW the cycle after
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("load_valid_low", {31'd0, valid_a}, 32'd0);
        tick();
        check("first_valid", {31'd0, valid_a}, 32'd1);
        check("first_line",  line_a, 32'hFFFFFFF1);
        check("first_isnum", {31'd0, isnum_a}, 32'd1);
        check("first_value", {20'd0, value_a}, 32'h001);

        // backpressure: hold ready low for 10 cycles
        for (int c = 0; c < 10; c++) tick();
        check("stall_valid", {31'd0, valid_a}, 32'd1);
        check("stall_line",  line_a, 32'hFFFFFFF1);
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        check("post_xfer_gap", {31'd0, valid_a}, 32'd0);
        tick();
        check("gap_one_cycle", {31'd0, valid_a}, 32'd1);
        check("second_line",   line_a, 32'hFFFFFFF2);

        // transfers 2..100, start pulsed during 4..6 must be ignored
        for (int i = 2; i <= 100; i++) begin
            start_a = (i >= 4 && i <= 6);
            get_line(1'b0, l, n, v);
            start_a = 1'b0;
            if (i == 3)  begin check("t3_line", l, 32'hFFFFEECB);  check("t3_isnum", {31'd0, n}, 32'd0); end
            if (i == 7)  check("t7_line", l, 32'hFFFFFFF7);
            if (i == 15) begin check("t15_line", l, 32'hEEDAEECB); check("t15_isnum", {31'd0, n}, 32'd0); end
            if (i == 97) begin check("t97_line", l, 32'hFFFFFF79); check("t97_isnum", {31'd0, n}, 32'd1); end
            if (i == 100) check("t100_value", {20'd0, v}, 32'h100);
        end

`ifdef FIZZBUZZ_GEN_WRAP_EN
        check("wrap_done", {31'd0, done_a},  32'd0);
        check("wrap_gap",  {31'd0, valid_a}, 32'd0);
        tick();
        check("wrap_done2", {31'd0, done_a}, 32'd0);
`else
        check("end_done",  {31'd0, done_a},  32'd1);
        check("end_valid", {31'd0, valid_a}, 32'd0);
        tick();
        check("end_done_hold", {31'd0, done_a}, 32'd1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
`endif
        check("restart_valid", {31'd0, valid_a}, 32'd1);
        check("restart_line",  line_a, 32'hFFFFFFF1);
        check("restart_value", {20'd0, value_a}, 32'h001);

        // LIMIT=200 instance: 101st line checks hundreds/tens/units ordering
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 1; i <= 101; i++) begin
            get_line(1'b1, l, n, v);
            if (i == 101) begin
                check("b101_line",  l, 32'hFFFFF101);
                check("b101_value", {20'd0, v}, 32'h101);
                check("b101_isnum", {31'd0, n}, 32'd1);
            end
        end

        // reset in the middle of SHOW
        check("pre_rst_valid", {31'd0, valid_a}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", {31'd0, valid_a}, 32'd0);
        check("midrst_line",  line_a, 32'hFFFFFFFF);
        check("midrst_value", {20'd0, value_a}, 32'd0);
        check("midrst_isnum", {31'd0, isnum_a}, 32'd0);
        check("midrst_done",  {31'd0, done_a}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
